// File: rtl/dot_product_pkg.sv
// Shared types and default widths for the dot-product sequencer slice.
package dot_product_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam int unsigned DefAW     = 32;
  localparam int unsigned DefBW     = 8;
  localparam int unsigned DefProdW  = 39;
  localparam int unsigned DefMulLat = 1;
  localparam int unsigned DefLenW   = 16;
  localparam int unsigned DefAccW   = 55;

endpackage

// File: rtl/dot_product_acc.sv
// Product accumulator. Define DOT_PRODUCT_ACC_SAT_EN for saturating adds with a sticky
// overflow flag; otherwise the sum wraps and ovf is tied low.
module dot_product_acc #(
  parameter int unsigned PROD_W = 39,
  parameter int unsigned ACC_W  = 55
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              add_en,
  input  logic [PROD_W-1:0] addend,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  logic [ACC_W-1:0] acc_q, acc_d;

`ifdef DOT_PRODUCT_ACC_SAT_EN
  logic [ACC_W:0] sum_wide;
  logic           ovf_q, ovf_d;

  always_comb begin
    sum_wide = {1'b0, acc_q} + (ACC_W + 1)'(addend);
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (add_en) begin
      // Carry out of the accumulator width means the true sum no longer fits.
      if (sum_wide[ACC_W]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum_wide[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + ACC_W'(addend);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign ovf = 1'b0;
`endif

  assign acc = acc_q;

endmodule

// File: rtl/dot_product_seq_ctrl.sv
// Sequences a shared registered multiplier over a vector of element pairs and returns the sum.
// Optional saturation via DOT_PRODUCT_ACC_SAT_EN (see dot_product_acc).
module dot_product_seq_ctrl
  import dot_product_pkg::*;
#(
  parameter int unsigned A_W     = DefAW,
  parameter int unsigned B_W     = DefBW,
  parameter int unsigned PROD_W  = DefProdW,
  parameter int unsigned MUL_LAT = DefMulLat,
  parameter int unsigned LEN_W   = DefLenW,
  parameter int unsigned ACC_W   = DefAccW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [A_W-1:0]    in_a,
  input  logic [B_W-1:0]    in_b,
  output logic              mul_ce,
  output logic [A_W-1:0]    mul_din0,
  output logic [B_W-1:0]    mul_din1,
  input  logic [PROD_W-1:0] mul_dout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_sum,
  output logic              res_ovf
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [MUL_LAT-1:0] vpipe_q, vpipe_d;
  logic [A_W-1:0]     din0_q;
  logic [B_W-1:0]     din1_q;
  logic [ACC_W-1:0]   res_sum_q, res_sum_d;
  logic [ACC_W-1:0]   acc;
  logic               acc_clr;
  logic               hs;

  assign in_ready = (state_q == StRun) && (rem_q != '0);
  assign hs       = in_ready && in_valid;
  assign busy     = (state_q != StIdle);
  assign mul_ce   = (state_q == StRun) || (state_q == StDrain);
  // Operands pass straight through on a handshake and hold their last value otherwise.
  assign mul_din0 = hs ? in_a : din0_q;
  assign mul_din1 = hs ? in_b : din1_q;
  assign res_valid = (state_q == StDone);
  assign res_sum   = res_sum_q;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    vpipe_d   = (vpipe_q << 1) | MUL_LAT'(hs);
    res_sum_d = res_sum_q;
    acc_clr   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_clr = 1'b1;
          if (len == '0) begin
            state_d   = StDone;
            res_sum_d = '0;
          end else begin
            state_d = StRun;
            rem_d   = len;
          end
        end
      end
      StRun: begin
        if (hs) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // An empty pipe means the final product was added on the previous edge.
        if (vpipe_q == '0) begin
          state_d   = StDone;
          res_sum_d = acc;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (clear) begin
      state_d = StIdle;
      rem_d   = '0;
      vpipe_d = '0;
      acc_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      vpipe_q   <= '0;
      din0_q    <= '0;
      din1_q    <= '0;
      res_sum_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      vpipe_q   <= vpipe_d;
      res_sum_q <= res_sum_d;
      if (hs) begin
        din0_q <= in_a;
        din1_q <= in_b;
      end
    end
  end

  dot_product_acc #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (acc_clr),
    .add_en  (vpipe_q[MUL_LAT-1]),
    .addend  (mul_dout),
    .acc     (acc),
    .ovf     (res_ovf)
  );

endmodule

// File: tb/tb_dot_product_seq_ctrl.sv
// Directed self-checking bench: a full-width instance plus a narrow 40-bit accumulator instance.
module tb_dot_product_seq_ctrl;

  localparam int unsigned AW      = 32;
  localparam int unsigned BW      = 8;
  localparam int unsigned LW      = 16;
  localparam int unsigned MulLat  = 1;
  // Full-range 32x8 operands need 40 product bits.
  localparam int unsigned PW      = 40;
  localparam int unsigned AccW    = 56;
  localparam int unsigned SatPW   = 39;
  localparam int unsigned SatAccW = 40;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic [LW-1:0] len = '0;
  logic in_valid = 1'b0;
  logic [AW-1:0] in_a = '0;
  logic [BW-1:0] in_b = '0;
  logic res_ready = 1'b0;

  logic busy, in_ready, mul_ce, res_valid, res_ovf;
  logic [AW-1:0] mul_din0;
  logic [BW-1:0] mul_din1;
  logic [PW-1:0] mul_dout = '0;
  logic [AccW-1:0] res_sum;

  logic busy2, in_ready2, mul_ce2, res_valid2, res_ovf2;
  logic [AW-1:0] mul_din0_2;
  logic [BW-1:0] mul_din1_2;
  logic [SatPW-1:0] mul_dout2 = '0;
  logic [SatAccW-1:0] res_sum2;

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  logic [AW-1:0] qa[$];
  logic [BW-1:0] qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference registered multiplier.
  always @(posedge clk) if (mul_ce) mul_dout <= PW'(mul_din0) * PW'(mul_din1);
  // Packing stub for the narrow instance: product = {b[6:0], a}, so a=FFFF_FFFF, b=7F gives 2^39-1.
  always @(posedge clk) if (mul_ce2) mul_dout2 <= {mul_din1_2[6:0], mul_din0_2};

  dot_product_seq_ctrl #(
    .A_W(AW), .B_W(BW), .PROD_W(PW), .MUL_LAT(MulLat), .LEN_W(LW), .ACC_W(AccW)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .mul_ce(mul_ce),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout), .res_valid(res_valid),
    .res_ready(res_ready), .res_sum(res_sum), .res_ovf(res_ovf)
  );

  dot_product_seq_ctrl #(
    .A_W(AW), .B_W(BW), .PROD_W(SatPW), .MUL_LAT(MulLat), .LEN_W(LW), .ACC_W(SatAccW)
  ) u_sat (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start(start), .len(len), .busy(busy2),
    .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b), .mul_ce(mul_ce2),
    .mul_din0(mul_din0_2), .mul_din1(mul_din1_2), .mul_dout(mul_dout2),
    .res_valid(res_valid2), .res_ready(res_ready), .res_sum(res_sum2), .res_ovf(res_ovf2)
  );

  // All stimulus tasks begin and end at a falling edge.
  task automatic kick(input logic [LW-1:0] n, output int unsigned t0);
    start = 1'b1;
    len = n;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input bit gaps, output bit ok);
    int idx = 0;
    int guard = 0;
    bit gap, hs;
    while (idx < qa.size() && guard < 200) begin
      gap = gaps && ($urandom_range(0, 2) == 0);
      in_valid = !gap;
      in_a = qa[idx];
      in_b = qb[idx];
      hs = !gap && in_ready;
      @(negedge clk);
      if (hs) idx++;
      guard++;
    end
    in_valid = 1'b0;
    ok = (idx == qa.size());
  endtask

  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, in_ready, mul_ce, res_valid, res_ovf} !== 5'b0)
      $display("FAIL reset_ctrl got=%b exp=00000", {busy, in_ready, mul_ce, res_valid, res_ovf});
    else n_pass++;
    n_checks++;
    if (res_sum !== '0 || res_sum2 !== '0)
      $display("FAIL reset_sum got=%0d/%0d exp=0/0", res_sum, res_sum2);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int unsigned t0;
    bit ok;
    qa = '{32'd1, 32'd2, 32'd3, 32'd4};
    qb = '{8'd5, 8'd6, 8'd7, 8'd8};
    kick(16'd4, t0);
    n_checks++;
    if ({busy, in_ready, mul_ce} !== 3'b111)
      $display("FAIL basic_run got=%b exp=111", {busy, in_ready, mul_ce});
    else n_pass++;
    feed(1'b0, ok);
    wait_result(ok);
    n_checks++;
    if (!ok) $display("FAIL basic_timeout got=no_result exp=result");
    else n_pass++;
    n_checks++;
    if (res_sum !== 56'd70) $display("FAIL basic_sum got=%0d exp=70", res_sum);
    else n_pass++;
    n_checks++;
    if (cyc - t0 - 1 !== 5 + MulLat)
      $display("FAIL basic_latency got=%0d exp=%0d", cyc - t0 - 1, 5 + MulLat);
    else n_pass++;
    consume();
    n_checks++;
    if ({busy, res_valid} !== 2'b00)
      $display("FAIL basic_idle got=%b exp=00", {busy, res_valid});
    else n_pass++;
  endtask

  task automatic test_gaps();
    int unsigned t0;
    bit ok;
    qa = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    qb = '{8'hFF, 8'hFF, 8'hFF};
    kick(16'd3, t0);
    feed(1'b1, ok);
    n_checks++;
    if (!ok) $display("FAIL gaps_feed got=stalled exp=all_accepted");
    else n_pass++;
    wait_result(ok);
    n_checks++;
    if (!ok || res_sum !== 56'd3285649980675 || res_ovf !== 1'b0)
      $display("FAIL gaps_sum got=%0d ovf=%0b exp=3285649980675 ovf=0", res_sum, res_ovf);
    else n_pass++;
    consume();
  endtask

  task automatic test_zero_len();
    int unsigned t0;
    in_valid = 1'b1;
    in_a = 32'd99;
    in_b = 8'd99;
    kick(16'd0, t0);
    n_checks++;
    if ({res_valid, in_ready} !== 2'b10 || res_sum !== '0)
      $display("FAIL zero_len got=v%0b r%0b sum=%0d exp=v1 r0 sum=0", res_valid, in_ready, res_sum);
    else n_pass++;
    consume();
    in_valid = 1'b0;
  endtask

  task automatic test_hold();
    int unsigned t0;
    bit ok;
    int bad = 0;
    qa = '{32'd10, 32'd20};
    qb = '{8'd1, 8'd2};
    kick(16'd2, t0);
    feed(1'b0, ok);
    wait_result(ok);
    for (int i = 0; i < 10; i++) begin
      if (!res_valid || res_sum !== 56'd50) bad++;
      start = i[0];
      len = 16'd7;
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (!ok || bad != 0) $display("FAIL hold_stable got=%0d unstable cycles exp=0", bad);
    else n_pass++;
    n_checks++;
    if (res_sum !== 56'd50) $display("FAIL hold_sum got=%0d exp=50", res_sum);
    else n_pass++;
    consume();
    n_checks++;
    if ({busy, res_valid} !== 2'b00)
      $display("FAIL hold_start_ignored got=%b exp=00", {busy, res_valid});
    else n_pass++;
  endtask

  task automatic test_clear();
    int unsigned t0;
    bit ok;
    kick(16'd5, t0);
    in_valid = 1'b1;
    in_a = 32'd1000;
    in_b = 8'd200;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_checks++;
    if ({busy, in_ready, res_valid} !== 3'b000)
      $display("FAIL clear_idle got=%b exp=000", {busy, in_ready, res_valid});
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL clear_no_result got=%0b exp=0", res_valid);
    else n_pass++;
    qa = '{32'd3, 32'd5};
    qb = '{8'd4, 8'd6};
    kick(16'd2, t0);
    feed(1'b0, ok);
    wait_result(ok);
    n_checks++;
    if (!ok || res_sum !== 56'd42) $display("FAIL clear_next_job got=%0d exp=42", res_sum);
    else n_pass++;
    consume();
  endtask

  task automatic test_back_to_back();
    int unsigned t0;
    bit ok;
    res_ready = 1'b1;
    qa = '{32'd7};
    qb = '{8'd3};
    kick(16'd1, t0);
    feed(1'b0, ok);
    wait_result(ok);
    n_checks++;
    if (!ok || res_sum !== 56'd21) $display("FAIL b2b_first got=%0d exp=21", res_sum);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, res_valid} !== 2'b00) $display("FAIL b2b_idle got=%b exp=00", {busy, res_valid});
    else n_pass++;
    qa = '{32'd2};
    qb = '{8'd2};
    kick(16'd1, t0);
    feed(1'b0, ok);
    wait_result(ok);
    n_checks++;
    if (!ok || res_sum !== 56'd4) $display("FAIL b2b_second got=%0d exp=4", res_sum);
    else n_pass++;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_sat();
    int unsigned t0;
    bit ok;
    // Three maximal 39-bit products exceed 2^40-1.
    qa = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    qb = '{8'h7F, 8'h7F, 8'h7F};
    kick(16'd3, t0);
    feed(1'b0, ok);
    wait_result(ok);
    n_checks++;
    if (!ok || res_sum !== 56'd1636382539395 || res_ovf !== 1'b0)
      $display("FAIL sat_wide got=%0d ovf=%0b exp=1636382539395 ovf=0", res_sum, res_ovf);
    else n_pass++;
    n_checks++;
`ifdef DOT_PRODUCT_ACC_SAT_EN
    if (res_valid2 !== 1'b1 || res_sum2 !== 40'hFF_FFFF_FFFF || res_ovf2 !== 1'b1)
      $display("FAIL sat_narrow got=%h ovf=%0b exp=ffffffffff ovf=1", res_sum2, res_ovf2);
    else n_pass++;
`else
    if (res_valid2 !== 1'b1 || res_sum2 !== 40'h7F_FFFF_FFFD || res_ovf2 !== 1'b0)
      $display("FAIL wrap_narrow got=%h ovf=%0b exp=7ffffffffd ovf=0", res_sum2, res_ovf2);
    else n_pass++;
`endif
    consume();
  endtask

  task automatic test_reset_mid_job();
    int unsigned t0;
    bit ok;
    kick(16'd3, t0);
    in_valid = 1'b1;
    in_a = 32'd100;
    in_b = 8'd100;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, in_ready, mul_ce} !== 3'b000)
      $display("FAIL reset_async got=%b exp=000", {busy, in_ready, mul_ce});
    else n_pass++;
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    qa = '{32'd9};
    qb = '{8'd9};
    kick(16'd1, t0);
    feed(1'b0, ok);
    wait_result(ok);
    n_checks++;
    if (!ok || res_sum !== 56'd81) $display("FAIL reset_discard got=%0d exp=81", res_sum);
    else n_pass++;
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero_len();
    test_hold();
    test_clear();
    test_back_to_back();
    test_sat();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
